mem_sync_sp: RTL and testbench

MEM_SYNC_SP -- requirements
Module: mem_sync_sp

---
 rtl/mem_sync_sp.sv | 49 ++++
 tb/tb_mem_sync_sp.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sync_sp.sv
// mem_sync_sp: single-port synchronous RAM with per-byte write enables and a one-cycle registered read.
// Define MEM_SYNC_SP_WRITE_FIRST_EN for write-first read-during-write; read-first otherwise.
module mem_sync_sp #(
  parameter int DEPTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int INIT_ZERO = 0,
  localparam int ADDR_WIDTH = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH),
  localparam int DATA_BYTES = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_BYTES-1:0] i_wen,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] =
    '{default: (INIT_ZERO != 0) ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'bx}}};
  logic                  in_range;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  always_comb begin
    in_range = {1'b0, i_addr} < DEPTH_LIM;
    old_word = in_range ? mem_q[i_addr] : '0;
    merged_d = old_word;
    for (int b = 0; b < DATA_BYTES; b++)
      if (i_wen[b]) merged_d[8*b +: 8] = i_wdata[8*b +: 8];
    wr_en = in_range && (|i_wen);
`ifdef MEM_SYNC_SP_WRITE_FIRST_EN
    rdata_d = in_range ? merged_d : '0;
`else
    rdata_d = old_word;
`endif
  end
  // The array shares the reset block only so that writes are blocked while rst is high; it is never cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      if (wr_en) mem_q[i_addr] <= merged_d;
    end
  end
  assign o_rdata = rdata_q;
endmodule

// File: tb/tb_mem_sync_sp.sv
// tb_mem_sync_sp: directed bench for mem_sync_sp, a DEPTH=16 instance and a DEPTH=12 instance.
module tb_mem_sync_sp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addr = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  wen = '0;
  logic [63:0] rdata;
  logic [3:0]  addr12 = '0;
  logic [63:0] wdata12 = '0;
  logic [7:0]  wen12 = '0;
  logic [63:0] rdata12;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_sync_sp #(.DEPTH(16), .DATA_WIDTH(64), .INIT_ZERO(1)) u_dut (
    .clk(clk), .rst(rst), .i_addr(addr), .i_wdata(wdata), .i_wen(wen), .o_rdata(rdata)
  );

  mem_sync_sp #(.DEPTH(12), .DATA_WIDTH(64), .INIT_ZERO(1)) u_dut12 (
    .clk(clk), .rst(rst), .i_addr(addr12), .i_wdata(wdata12), .i_wen(wen12), .o_rdata(rdata12)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick();
    tick();
    total++;
    if (rdata !== 64'h0) begin
      bad++;
      $display("FAIL reset_rdata16 got=%h exp=%h", rdata, 64'h0);
    end
    total++;
    if (rdata12 !== 64'h0) begin
      bad++;
      $display("FAIL reset_rdata12 got=%h exp=%h", rdata12, 64'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_init_zero;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      wen = '0;
      tick();
      total++;
      if (rdata !== 64'h0) begin
        bad++;
        $display("FAIL init_zero addr=%0d got=%h exp=%h", a, rdata, 64'h0);
      end
    end
  endtask

  task automatic test_byte_write;
    logic [63:0] exp;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      wdata = 64'h00000000FFFFFF00 | 64'(16 - i);
      wen = 8'h05;
      tick();
    end
    wen = '0;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      tick();
      exp = 64'h0000000000FF0000 | 64'(16 - i);
      total++;
      if (rdata !== exp) begin
        bad++;
        $display("FAIL byte_write addr=%0d got=%h exp=%h", i, rdata, exp);
      end
    end
  endtask

  task automatic test_read_during_write;
    logic [63:0] exp;
    addr = 4'd3;
    wdata = 64'h1122334455667788;
    wen = 8'hFF;
    tick();
`ifdef MEM_SYNC_SP_WRITE_FIRST_EN
    exp = 64'h1122334455667788;
`else
    exp = 64'h0000000000FF000D;
`endif
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL rdw_full got=%h exp=%h", rdata, exp);
    end
    wen = '0;
    tick();
    total++;
    if (rdata !== 64'h1122334455667788) begin
      bad++;
      $display("FAIL rdw_full_after got=%h exp=%h", rdata, 64'h1122334455667788);
    end
    wdata = 64'hAA00000000000000;
    wen = 8'h80;
    tick();
`ifdef MEM_SYNC_SP_WRITE_FIRST_EN
    exp = 64'hAA22334455667788;
`else
    exp = 64'h1122334455667788;
`endif
    total++;
    if (rdata !== exp) begin
      bad++;
      $display("FAIL rdw_partial got=%h exp=%h", rdata, exp);
    end
    wen = '0;
    tick();
    total++;
    if (rdata !== 64'hAA22334455667788) begin
      bad++;
      $display("FAIL rdw_partial_after got=%h exp=%h", rdata, 64'hAA22334455667788);
    end
  endtask

  task automatic test_wen_zero;
    addr = 4'd5;
    wdata = '1;
    wen = '0;
    tick();
    tick();
    total++;
    if (rdata !== 64'h0000000000FF000B) begin
      bad++;
      $display("FAIL wen_zero got=%h exp=%h", rdata, 64'h0000000000FF000B);
    end
  endtask

  task automatic test_async_reset;
    addr = 4'd3;
    wen = '0;
    tick();
    total++;
    if (rdata !== 64'hAA22334455667788) begin
      bad++;
      $display("FAIL pre_reset got=%h exp=%h", rdata, 64'hAA22334455667788);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (rdata !== 64'h0) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", rdata, 64'h0);
    end
    addr = 4'd4;
    wdata = 64'hDEADBEEFCAFEF00D;
    wen = 8'hFF;
    tick();
    total++;
    if (rdata !== 64'h0) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=%h", rdata, 64'h0);
    end
    rst = 1'b0;
    wen = '0;
    tick();
    total++;
    if (rdata !== 64'h0000000000FF000C) begin
      bad++;
      $display("FAIL write_in_reset got=%h exp=%h", rdata, 64'h0000000000FF000C);
    end
    addr = 4'd3;
    tick();
    total++;
    if (rdata !== 64'hAA22334455667788) begin
      bad++;
      $display("FAIL reset_keeps_array got=%h exp=%h", rdata, 64'hAA22334455667788);
    end
  endtask

  task automatic test_out_of_range;
    logic [63:0] exp;
    for (int i = 0; i < 12; i++) begin
      addr12 = 4'(i);
      wdata12 = 64'hA5A5000000000000 | 64'(i);
      wen12 = 8'hFF;
      tick();
    end
    addr12 = 4'd13;
    wdata12 = '1;
    wen12 = 8'hFF;
    tick();
    total++;
    if (rdata12 !== 64'h0) begin
      bad++;
      $display("FAIL oor_write_cycle got=%h exp=%h", rdata12, 64'h0);
    end
    addr12 = 4'd12;
    tick();
    wen12 = '0;
    addr12 = 4'd13;
    tick();
    total++;
    if (rdata12 !== 64'h0) begin
      bad++;
      $display("FAIL oor_read13 got=%h exp=%h", rdata12, 64'h0);
    end
    addr12 = 4'd12;
    tick();
    total++;
    if (rdata12 !== 64'h0) begin
      bad++;
      $display("FAIL oor_read12 got=%h exp=%h", rdata12, 64'h0);
    end
    for (int i = 0; i < 12; i++) begin
      addr12 = 4'(i);
      tick();
      exp = 64'hA5A5000000000000 | 64'(i);
      total++;
      if (rdata12 !== exp) begin
        bad++;
        $display("FAIL oor_array addr=%0d got=%h exp=%h", i, rdata12, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_zero();
    test_byte_write();
    test_read_during_write();
    test_wen_zero();
    test_async_reset();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
